// File: rtl/regfile_nport.sv
// Two-write, three-read register file on a two-phase clock. A hardware sweep
// zeroes every register after reset or on request, so the array needs no reset.
module regfile_nport #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ADRW     = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             clr,
  input  logic             we1,
  input  logic             we2,
  input  logic [ADRW-1:0]  wa1,
  input  logic [ADRW-1:0]  wa2,
  input  logic [WIDTH-1:0] wd1,
  input  logic [WIDTH-1:0] wd2,
  input  logic [ADRW-1:0]  ra1,
  input  logic [ADRW-1:0]  ra2,
  input  logic [ADRW-1:0]  ra3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             busy,
  output logic             clr_done
);

  localparam logic [0:0]      S_READY = 1'b0;
  localparam logic [0:0]      S_CLEAR = 1'b1;
  localparam logic [ADRW-1:0] LAST    = ADRW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [0:0]      state, state_d, state_q;
  logic [ADRW-1:0] idx, idx_d, idx_q;

  // Pending updates: sampled while ph2 is high, applied when ph1 rises.
  logic             p_we1, p_we2, p_cwe;
  logic [ADRW-1:0]  p_wa1, p_wa2;
  logic [WIDTH-1:0] p_wd1, p_wd2;

  logic w1_ok, w2_ok;
  logic [ADRW-1:0]  ra_a [3];
  logic [WIDTH-1:0] rd_a [3];

  function automatic logic in_range(input logic [ADRW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic is_zero(input logic [ADRW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign busy     = reset || (state == S_CLEAR);
  assign clr_done = (state == S_CLEAR) && (idx == LAST) && !clr && !reset;

  // Port 1 wins a same-address collision, so port 2 yields whenever port 1 writes there.
  assign w1_ok = we1 && !busy && !clr && in_range(wa1) && !is_zero(wa1);
  assign w2_ok = we2 && !busy && !clr && in_range(wa2) && !is_zero(wa2)
                 && !(w1_ok && (wa2 == wa1));

  always_comb begin
    state_d = state;
    idx_d   = idx;
    if (reset || clr) begin
      state_d = S_CLEAR;
      idx_d   = '0;
    end else if (state == S_CLEAR) begin
      if (idx == LAST) begin
        state_d = S_READY;
        idx_d   = '0;
      end else begin
        idx_d = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge ph2) begin
    state_q <= state_d;
    idx_q   <= idx_d;
    p_cwe   <= (state == S_CLEAR);
    p_we1   <= w1_ok;
    p_wa1   <= wa1;
    p_wd1   <= wd1;
    p_we2   <= w2_ok;
    p_wa2   <= wa2;
    p_wd2   <= wd2;
  end

  // idx is still this cycle's value here, so the sweep clears the slot it announced.
  always_ff @(posedge ph1) begin
    state <= state_q;
    idx   <= idx_q;
    if (p_we1) mem[p_wa1] <= p_wd1;
    if (p_we2) mem[p_wa2] <= p_wd2;
    if (p_cwe) mem[idx] <= '0;
  end

  always_comb begin
    ra_a[0] = ra1;
    ra_a[1] = ra2;
    ra_a[2] = ra3;
    for (int p = 0; p < 3; p++) begin
      rd_a[p] = '0;
      if (!busy && in_range(ra_a[p]) && !is_zero(ra_a[p])) begin
        rd_a[p] = mem[ra_a[p]];
        if (BYPASS) begin
          if (w2_ok && (wa2 == ra_a[p])) rd_a[p] = wd2;
          if (w1_ok && (wa1 == ra_a[p])) rd_a[p] = wd1;
        end
      end
    end
  end

  assign rd1 = rd_a[0];
  assign rd2 = rd_a[1];
  assign rd3 = rd_a[2];

endmodule

// File: tb/tb_regfile_nport.sv
// Directed bench: three instances (default, BYPASS=1, DEPTH=6) share all inputs
// and each scenario task checks the instances it targets.
module tb_regfile_nport;

  logic       ph1, ph2, reset, clr, we1, we2;
  logic [2:0] wa1, wa2, ra1, ra2, ra3;
  logic [7:0] wd1, wd2;

  logic [7:0] a_rd1, a_rd2, a_rd3, b_rd1, b_rd2, b_rd3, c_rd1, c_rd2, c_rd3;
  logic       a_busy, a_done, b_busy, b_done, c_busy, c_done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];

  regfile_nport u0 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .clr(clr),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .rd1(a_rd1), .rd2(a_rd2), .rd3(a_rd3),
    .busy(a_busy), .clr_done(a_done)
  );

  regfile_nport #(.BYPASS(1'b1)) u1 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .clr(clr),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .rd1(b_rd1), .rd2(b_rd2), .rd3(b_rd3),
    .busy(b_busy), .clr_done(b_done)
  );

  regfile_nport #(.DEPTH(6)) u2 (
    .ph1(ph1), .ph2(ph2), .reset(reset), .clr(clr),
    .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .rd1(c_rd1), .rd2(c_rd2), .rd3(c_rd3),
    .busy(c_busy), .clr_done(c_done)
  );

  // clock / reset
  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    #5;
    forever begin
      ph1 = 1'b1; #10;
      ph1 = 1'b0; #30;
      ph2 = 1'b1; #10;
      ph2 = 1'b0; #10;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(negedge ph1);
    #2;
  endtask

  task automatic idle();
    reset = 1'b0; clr = 1'b0; we1 = 1'b0; we2 = 1'b0;
  endtask

  task automatic test_reset();
    step();
    idle();
    reset = 1'b1; wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
    ra1 = 3'd1; ra2 = 3'd2; ra3 = 3'd3;
    #1;
    n_checks++; if (a_busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", a_busy); else n_pass++;
    n_checks++; if (a_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", a_done); else n_pass++;
    n_checks++; if (a_rd1 !== 8'h00) $display("FAIL rst_rd1: got %h expected 00", a_rd1); else n_pass++;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      ra1 = 3'(i); ra2 = 3'(i + 3); ra3 = 3'd7;
      #1;
      n_checks++; if (a_busy !== (i <= 8)) $display("FAIL sweep_busy[%0d]: got %b expected %b", i, a_busy, i <= 8); else n_pass++;
      n_checks++; if (a_done !== (i == 8)) $display("FAIL sweep_done[%0d]: got %b expected %b", i, a_done, i == 8); else n_pass++;
      n_checks++; if (b_busy !== (i <= 8)) $display("FAIL sweep_busy_b[%0d]: got %b expected %b", i, b_busy, i <= 8); else n_pass++;
      n_checks++; if (c_busy !== (i <= 6)) $display("FAIL sweep_busy_d6[%0d]: got %b expected %b", i, c_busy, i <= 6); else n_pass++;
      n_checks++; if (c_done !== (i == 6)) $display("FAIL sweep_done_d6[%0d]: got %b expected %b", i, c_done, i == 6); else n_pass++;
      n_checks++; if (a_rd2 !== 8'h00) $display("FAIL sweep_rd2[%0d]: got %h expected 00", i, a_rd2); else n_pass++;
      step();
    end
    for (int r = 0; r < 8; r++) begin
      ra1 = 3'(r); ra2 = 3'(r); ra3 = 3'(r);
      #1;
      n_checks++; if (a_rd1 !== 8'h00) $display("FAIL post_rst_rd[%0d]: got %h expected 00", r, a_rd1); else n_pass++;
      n_checks++; if (b_rd2 !== 8'h00) $display("FAIL post_rst_rd_b[%0d]: got %h expected 00", r, b_rd2); else n_pass++;
      n_checks++; if (c_rd3 !== 8'h00) $display("FAIL post_rst_rd_d6[%0d]: got %h expected 00", r, c_rd3); else n_pass++;
    end
  endtask

  task automatic test_write_read();
    step();
    idle();
    we1 = 1'b1; wa1 = 3'd3; wd1 = 8'h5A; ra1 = 3'd3;
    #1;
    n_checks++; if (a_rd1 !== 8'h00) $display("FAIL wr_same_cycle: got %h expected 00", a_rd1); else n_pass++;
    n_checks++; if (b_rd1 !== 8'h5A) $display("FAIL wr_bypass: got %h expected 5a", b_rd1); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (a_rd1 !== 8'h5A) $display("FAIL wr_next_cycle: got %h expected 5a", a_rd1); else n_pass++;
    n_checks++; if (c_rd1 !== 8'h5A) $display("FAIL wr_next_d6: got %h expected 5a", c_rd1); else n_pass++;
  endtask

  task automatic test_collision();
    step();
    idle();
    we1 = 1'b1; we2 = 1'b1; wa1 = 3'd5; wa2 = 3'd5; wd1 = 8'h11; wd2 = 8'h22; ra2 = 3'd5;
    #1;
    n_checks++; if (b_rd2 !== 8'h11) $display("FAIL coll_bypass: got %h expected 11", b_rd2); else n_pass++;
    n_checks++; if (a_rd2 !== 8'h00) $display("FAIL coll_old: got %h expected 00", a_rd2); else n_pass++;
    step();
    idle();
    we1 = 1'b1; we2 = 1'b1; wa1 = 3'd2; wa2 = 3'd4; wd1 = 8'hAA; wd2 = 8'hBB;
    ra1 = 3'd2; ra3 = 3'd4;
    #1;
    n_checks++; if (a_rd2 !== 8'h11) $display("FAIL coll_stored: got %h expected 11", a_rd2); else n_pass++;
    n_checks++; if (b_rd3 !== 8'hBB) $display("FAIL bypass_port2: got %h expected bb", b_rd3); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (a_rd1 !== 8'hAA) $display("FAIL dual_wr1: got %h expected aa", a_rd1); else n_pass++;
    n_checks++; if (a_rd3 !== 8'hBB) $display("FAIL dual_wr2: got %h expected bb", a_rd3); else n_pass++;
    ra1 = 3'd5; ra2 = 3'd5; ra3 = 3'd5;
    #1;
    n_checks++; if (a_rd1 !== 8'h11) $display("FAIL same_ra_1: got %h expected 11", a_rd1); else n_pass++;
    n_checks++; if (a_rd2 !== 8'h11) $display("FAIL same_ra_2: got %h expected 11", a_rd2); else n_pass++;
    n_checks++; if (a_rd3 !== 8'h11) $display("FAIL same_ra_3: got %h expected 11", a_rd3); else n_pass++;
  endtask

  task automatic test_zero_reg();
    step();
    idle();
    we1 = 1'b1; wa1 = 3'd0; wd1 = 8'hFF; ra1 = 3'd0; ra2 = 3'd0;
    #1;
    n_checks++; if (a_rd1 !== 8'h00) $display("FAIL zero_same: got %h expected 00", a_rd1); else n_pass++;
    n_checks++; if (b_rd1 !== 8'h00) $display("FAIL zero_bypass: got %h expected 00", b_rd1); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      idle();
      #1;
      n_checks++; if (a_rd1 !== 8'h00) $display("FAIL zero_later[%0d]: got %h expected 00", i, a_rd1); else n_pass++;
      n_checks++; if (b_rd2 !== 8'h00) $display("FAIL zero_later_b[%0d]: got %h expected 00", i, b_rd2); else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    step();
    idle();
    we1 = 1'b1; wa1 = 3'd7; wd1 = 8'h77; we2 = 1'b1; wa2 = 3'd6; wd2 = 8'h66;
    ra1 = 3'd7; ra2 = 3'd6;
    #1;
    n_checks++; if (c_rd1 !== 8'h00) $display("FAIL oor_same: got %h expected 00", c_rd1); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (c_rd1 !== 8'h00) $display("FAIL oor_rd7: got %h expected 00", c_rd1); else n_pass++;
    n_checks++; if (c_rd2 !== 8'h00) $display("FAIL oor_rd6: got %h expected 00", c_rd2); else n_pass++;
    n_checks++; if (a_rd1 !== 8'h77) $display("FAIL inrange_d8: got %h expected 77", a_rd1); else n_pass++;
  endtask

  task automatic test_clear();
    logic [7:0] e;
    for (int r = 1; r < 8; r++) begin
      step();
      idle();
      we1 = 1'b1; wa1 = 3'(r); wd1 = 8'(r * 17);
      exp_q.push_back(8'(r * 17));
    end
    step();
    idle();
    for (int r = 1; r < 8; r++) begin
      ra1 = 3'(r);
      #1;
      e = exp_q.pop_front();
      n_checks++; if (a_rd1 !== e) $display("FAIL load[%0d]: got %h expected %h", r, a_rd1, e); else n_pass++;
    end
    step();
    clr = 1'b1;
    #1;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL clr_cycle_busy: got %b expected 0", a_busy); else n_pass++;
    step();
    clr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      we1 = (i <= 8); wa1 = 3'(i); wd1 = 8'hEE;
      we2 = (i <= 8); wa2 = 3'(i + 2); wd2 = 8'hDD;
      ra1 = 3'(i);
      #1;
      n_checks++; if (a_busy !== (i <= 8)) $display("FAIL clr_busy[%0d]: got %b expected %b", i, a_busy, i <= 8); else n_pass++;
      n_checks++; if (a_done !== (i == 8)) $display("FAIL clr_done[%0d]: got %b expected %b", i, a_done, i == 8); else n_pass++;
      n_checks++; if (b_rd1 !== 8'h00) $display("FAIL clr_rd[%0d]: got %h expected 00", i, b_rd1); else n_pass++;
      step();
    end
    idle();
    for (int r = 0; r < 8; r++) begin
      ra1 = 3'(r); ra2 = 3'(r);
      #1;
      n_checks++; if (a_rd1 !== 8'h00) $display("FAIL cleared[%0d]: got %h expected 00", r, a_rd1); else n_pass++;
      n_checks++; if (b_rd2 !== 8'h00) $display("FAIL cleared_b[%0d]: got %h expected 00", r, b_rd2); else n_pass++;
    end
  endtask

  task automatic test_clr_restart();
    int ndone = 0;
    step();
    idle();
    we1 = 1'b1; wa1 = 3'd2; wd1 = 8'h42;
    step();
    idle();
    clr = 1'b1;
    step();
    for (int i = 1; i <= 13; i++) begin
      clr = (i == 4);
      ra1 = 3'd2;
      #1;
      if (a_done === 1'b1) ndone++;
      n_checks++; if (a_busy !== (i <= 12)) $display("FAIL rst_sweep_busy[%0d]: got %b expected %b", i, a_busy, i <= 12); else n_pass++;
      n_checks++; if (a_done !== (i == 12)) $display("FAIL rst_sweep_done[%0d]: got %b expected %b", i, a_done, i == 12); else n_pass++;
      n_checks++; if (c_busy !== (i <= 10)) $display("FAIL rst_sweep_busy_d6[%0d]: got %b expected %b", i, c_busy, i <= 10); else n_pass++;
      n_checks++; if (c_done !== (i == 10)) $display("FAIL rst_sweep_done_d6[%0d]: got %b expected %b", i, c_done, i == 10); else n_pass++;
      step();
    end
    clr = 1'b0;
    #1;
    n_checks++; if (ndone !== 1) $display("FAIL restart_pulses: got %0d expected 1", ndone); else n_pass++;
    n_checks++; if (a_rd1 !== 8'h00) $display("FAIL restart_r2: got %h expected 00", a_rd1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step();
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      reset = (i == 3);
      we1 = (i == 3); wa1 = 3'd1; wd1 = 8'h99;
      #1;
      n_checks++; if (a_busy !== (i <= 11)) $display("FAIL mid_rst_busy[%0d]: got %b expected %b", i, a_busy, i <= 11); else n_pass++;
      n_checks++; if (a_done !== (i == 11)) $display("FAIL mid_rst_done[%0d]: got %b expected %b", i, a_done, i == 11); else n_pass++;
      step();
    end
    idle();
    ra1 = 3'd1;
    #1;
    n_checks++; if (a_rd1 !== 8'h00) $display("FAIL mid_rst_wr_ignored: got %h expected 00", a_rd1); else n_pass++;
  endtask

  initial begin
    idle();
    wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0; ra1 = '0; ra2 = '0; ra3 = '0;
    test_reset();
    test_write_read();
    test_collision();
    test_zero_reg();
    test_out_of_range();
    test_clear();
    test_clr_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_nport.md
REGFILE_NPORT -- requirements
Module: regfile_nport

Interface
REQ-001 Parameter WIDTH, default 8: data width of each register, in bits.
REQ-002 Parameter DEPTH, default 8: number of registers; any value from 2 to 256, and it does not have to be a power of 2.
REQ-003 Parameter ADRW, default $clog2(DEPTH): width of every address port.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and writes to it are discarded.
REQ-005 Parameter BYPASS, default 0: when 1, a write in the current cycle is forwarded combinationally to any read port with a matching address.
REQ-006 ph1  input  1  non-overlapping two-phase clock, phase 1; flop outputs update while ph1 is high.
REQ-007 ph2  input  1  phase 2; next state is captured while ph2 is high; one ph1+ph2 pair is one cycle.
REQ-008 reset  input  1  reset, synchronous, active-high.
REQ-009 clr  input  1  request to clear the whole file; synchronous, sampled with ph2.
REQ-010 we1, we2  input  1 each  write enables for write ports 1 and 2.
REQ-011 wa1, wa2  input  ADRW each  write addresses for ports 1 and 2.
REQ-012 wd1, wd2  input  WIDTH each  write data for ports 1 and 2.
REQ-013 ra1, ra2, ra3  input  ADRW each  read addresses.
REQ-014 rd1, rd2, rd3  output  WIDTH each  read data, combinational from the read addresses.
REQ-015 busy  output  1  high while a clear sweep is in progress.
REQ-016 clr_done  output  1  one-cycle pulse on the last cycle of a clear sweep.

Function
REQ-017 The state machine SHALL have two states: READY and CLEAR.
REQ-018 CLEAR SHALL write zero to register idx every cycle, where idx is an ADRW-bit counter that starts at 0 and increments by 1 each cycle.
REQ-019 When idx reaches DEPTH-1, the block SHALL pulse clr_done, enter READY on the next cycle and return idx to 0; idx never exceeds DEPTH-1.
REQ-020 A clear sweep SHALL take exactly DEPTH cycles, with busy=1 for those DEPTH cycles.
REQ-021 In READY, clr=1 SHALL enter CLEAR with idx=0 on the next cycle.
REQ-022 clr=1 while already in CLEAR SHALL restart the sweep, setting idx to 0; clr_done is not pulsed for the aborted sweep.
REQ-023 While busy=1, we1/we2 SHALL be ignored and rd1..rd3 SHALL read 0.
REQ-024 In READY, a write with weN=1 SHALL be captured during the ph2 of that cycle and SHALL be visible on the read ports from the ph1 of the next cycle.
REQ-025 If we1=we2=1 and wa1==wa2, port 1's data SHALL be stored and port 2's data discarded.
REQ-026 With BYPASS=1, a read whose address matches an active write in the same cycle SHALL return that cycle's write data, applying the REQ-025 priority; bypass is suppressed for register 0 when ZERO_REG=1, and while busy.
REQ-027 With BYPASS=0, a read-during-write to the same address SHALL return the old contents.
REQ-028 Writes and reads with an address >= DEPTH SHALL be ignored; such reads return 0.
REQ-029 With ZERO_REG=1, reads of register 0 SHALL return 0 regardless of any write to it.
REQ-030 The three read ports SHALL be fully independent: any combination of addresses, including all three equal, is legal.

Reset
REQ-031 reset=1 sampled during ph2 SHALL force state CLEAR with idx=0 on the next cycle, so that every register is zeroed by hardware rather than by an asynchronous array reset.
REQ-032 During reset and the following sweep, the outputs SHALL be busy=1, clr_done=0 (except on the final sweep cycle) and rd1..rd3=0.
REQ-033 reset SHALL override clr and all writes.
REQ-034 reset asserted mid-sweep SHALL restart the sweep at idx=0.
REQ-035 The reset-triggered sweep SHALL end exactly as in REQ-019, with clr_done pulsed on the last cycle.
REQ-036 Array contents SHALL be undefined only between power-up and the end of the first reset-triggered sweep.

Verification
REQ-037 Reset, defaults: hold reset 1 cycle then release -> busy=1 for exactly 8 cycles, clr_done pulses on the 8th, busy=0 on the 9th, all reads return 0x00.
REQ-038 Write/read: write 0x5A to r3 via port 1 -> in the same cycle rd1(ra1=3)=0x00 (BYPASS=0); on the next cycle rd1=0x5A.
REQ-039 Collision: we1=we2=1, wa1=wa2=5, wd1=0x11, wd2=0x22 -> r5=0x11 afterwards. With BYPASS=1, ra2=5 returns 0x11 in the same cycle.
REQ-040 Zero register: with ZERO_REG=1, write 0xFF to r0 -> rd=0x00 on that cycle and every later cycle.
REQ-041 clr mid-operation: load r1..r7 with nonzero values, assert clr -> busy for 8 cycles, writes attempted during the sweep are ignored, all registers read 0x00 afterwards. Asserting clr again at sweep cycle 4 -> busy extends to 4+8 cycles and clr_done pulses only once.
REQ-042 Non-power-of-2 depth: with DEPTH=6, sweep lasts 6 cycles and idx wraps 5->0. Write to address 7 is ignored and a read of address 7 returns 0.
